axi_mem_master: RTL
===================

AXI_MEM_MASTER -- requirements
Module: axi_mem_master

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 64, AXI data width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have req_valid  input  1  CPU request valid.
REQ-007 SHALL have req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL have req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have req_id  input  AXI_ID_WIDTH  transaction ID (1 = instruction fetch, 0 = data).
REQ-010 SHALL have req_addr  input  AXI_ADDR_WIDTH  byte address.
REQ-011 SHALL have req_size  input  3  AXI size code.
REQ-012 SHALL have req_len  input  8  read beats minus 1; ignored for writes.
REQ-013 SHALL have req_wdata / req_wstrb  input  AXI_DATA_WIDTH / AXI_DATA_WIDTH/8  write data and byte strobes.
REQ-014 SHALL have rsp_valid  output  1  one-cycle response pulse per beat; no backpressure.
REQ-015 SHALL have rsp_data  output  AXI_DATA_WIDTH  read beat data; 0 for writes.
REQ-016 SHALL have rsp_last / rsp_err  output  1 / 1  final beat / non-OKAY resp.
REQ-017 SHALL drive AXI master ports for AW (valid,id,addr,len,size,burst), W (valid,data,strb,last), B (ready) and AR (valid,id,addr,len,size,burst), and accept AW/W/AR ready, B (valid,id,resp) and R (valid,id,resp,data,last), at standard AXI4 widths.

Function
REQ-018 SHALL implement states IDLE, AR, R, AWW, B; one outstanding transaction.
REQ-019 SHALL drive req_ready = 1 only in IDLE (combinational from state).
REQ-020 SHALL, on req_valid & req_ready, latch all req_* fields and enter AR (read) or AWW (write).
REQ-021 SHALL, in AR, hold axi_ar_valid high with stable fields (burst = INCR 2'b01, len = req_len) until axi_ar_ready, then enter R.
REQ-022 SHALL, in R, hold axi_r_ready high; each R handshake produces rsp_valid one cycle later with rsp_data = r_data and rsp_err = (r_resp != 0).
REQ-023 SHALL count R beats and return to IDLE on beat number req_len+1; rsp_last marks that beat; rsp_err SHALL be set if r_last disagrees with the count.
REQ-024 SHALL, in AWW, assert axi_aw_valid (len 0, INCR) and axi_w_valid (w_last = 1) together; each deasserts after its own handshake, in either order or the same cycle.
REQ-025 SHALL enter B once both AW and W have handshaken; in B it SHALL hold axi_b_ready high until b_valid.
REQ-026 SHALL then pulse rsp_valid with rsp_last = 1, rsp_data = 0, rsp_err = (b_resp != 0), and return to IDLE.
REQ-027 SHALL give minimum read latency of 3 cycles, from request acceptance to rsp_valid, with zero-wait slave.
REQ-028 SHALL ignore req_valid outside IDLE; a new request SHALL NOT be accepted on the cycle a response completes.

Reset
REQ-029 SHALL, on rst, force IDLE, clear all AXI valid/ready outputs, rsp_valid, rsp_last, rsp_err, rsp_data and the beat counter to 0, and drive req_ready 1 the following cycle.
REQ-030 SHALL abandon any in-flight transaction on rst, issuing no response.

Structure
REQ-031 SHALL take the state encoding and the AXI constants BURST_INCR = 2'b01 and RESP_OKAY = 2'b00 from the shared package.
REQ-032 SHALL be a single module; no sub-module is natural.

Verification
REQ-033 Single read 0x80000000, ID 1, slave ar_ready = 1, r_data 0x1122334455667788 -> rsp_valid 3 cycles after accept, rsp_last = 1, rsp_err = 0.
REQ-034 Burst read len 3 with r_valid gaps -> 4 rsp pulses in order, rsp_last only on the 4th, then req_ready = 1.
REQ-035 Write 0x02004000, wstrb 0xFF; aw_ready delayed 2 cycles, w_ready immediate -> w_valid drops first, B entered after AW, one rsp pulse with rsp_last = 1.
REQ-036 Write with b_resp = 2'b10 -> rsp_err = 1.
REQ-037 Read len 1 with r_last set on the first beat -> rsp_err = 1 on that beat.
REQ-038 rst asserted in R mid-burst -> all valids 0 next cycle, no further rsp, req_ready = 1 after release.

Source files
------------

// File: rtl/axi_mem_master_pkg.sv
// rtl/axi_mem_master_pkg.sv - shared state encoding and AXI constants for axi_mem_master
package axi_mem_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AWW  = 3'd3,
        ST_B    = 3'd4
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_mem_master.sv
// rtl/axi_mem_master.sv - single-outstanding CPU request to AXI4 master bridge
module axi_mem_master
    import axi_mem_master_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ID_WIDTH-1:0]     req_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [2:0]                  req_size,
    input  logic [7:0]                  req_len,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
    output logic                        rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_data,
    output logic                        rsp_last,
    output logic                        rsp_err,
    output logic                        axi_aw_valid,
    input  logic                        axi_aw_ready,
    output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
    output logic [7:0]                  axi_aw_len,
    output logic [2:0]                  axi_aw_size,
    output logic [1:0]                  axi_aw_burst,
    output logic                        axi_w_valid,
    input  logic                        axi_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
    output logic                        axi_w_last,
    input  logic                        axi_b_valid,
    output logic                        axi_b_ready,
    input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
    input  logic [1:0]                  axi_b_resp,
    output logic                        axi_ar_valid,
    input  logic                        axi_ar_ready,
    output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
    output logic [7:0]                  axi_ar_len,
    output logic [2:0]                  axi_ar_size,
    output logic [1:0]                  axi_ar_burst,
    input  logic                        axi_r_valid,
    output logic                        axi_r_ready,
    input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
    input  logic [1:0]                  axi_r_resp,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
    input  logic                        axi_r_last
);

    state_t                        state, state_nx;
    logic [AXI_ID_WIDTH-1:0]       id_q;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [2:0]                    size_q;
    logic [7:0]                    len_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [7:0]                    beat_cnt;
    logic                          aw_done, w_done;
    logic                          final_beat;

    // Response IDs are not checked: with one transaction outstanding they carry no information.
    logic unused_ids;
    assign unused_ids = ^{axi_b_id, axi_r_id};

    assign final_beat = (beat_cnt == len_q);

    assign axi_ar_id    = id_q;
    assign axi_ar_addr  = addr_q;
    assign axi_ar_len   = len_q;
    assign axi_ar_size  = size_q;
    assign axi_ar_burst = BURST_INCR;
    assign axi_aw_id    = id_q;
    assign axi_aw_addr  = addr_q;
    assign axi_aw_len   = 8'd0;
    assign axi_aw_size  = size_q;
    assign axi_aw_burst = BURST_INCR;
    assign axi_w_data   = wdata_q;
    assign axi_w_strb   = wstrb_q;
    assign axi_w_last   = 1'b1;

    always_comb begin
        state_nx     = state;
        req_ready    = 1'b0;
        axi_ar_valid = 1'b0;
        axi_r_ready  = 1'b0;
        axi_aw_valid = 1'b0;
        axi_w_valid  = 1'b0;
        axi_b_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_we ? ST_AWW : ST_AR;
            end
            ST_AR: begin
                axi_ar_valid = 1'b1;
                if (axi_ar_ready) state_nx = ST_R;
            end
            ST_R: begin
                axi_r_ready = 1'b1;
                if (axi_r_valid && final_beat) state_nx = ST_IDLE;
            end
            ST_AWW: begin
                // AW and W are independent; each valid drops once its own handshake is recorded.
                axi_aw_valid = !aw_done;
                axi_w_valid  = !w_done;
                if ((aw_done || axi_aw_ready) && (w_done || axi_w_ready)) state_nx = ST_B;
            end
            ST_B: begin
                axi_b_ready = 1'b1;
                if (axi_b_valid) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat_cnt  <= 8'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    id_q     <= req_id;
                    addr_q   <= req_addr;
                    size_q   <= req_size;
                    len_q    <= req_len;
                    wdata_q  <= req_wdata;
                    wstrb_q  <= req_wstrb;
                    beat_cnt <= 8'd0;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                end
                ST_R: if (axi_r_valid) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= axi_r_data;
                    rsp_last  <= final_beat;
                    rsp_err   <= (axi_r_resp != RESP_OKAY) || (axi_r_last != final_beat);
                    beat_cnt  <= beat_cnt + 8'd1;
                end
                ST_AWW: begin
                    if (axi_aw_ready) aw_done <= 1'b1;
                    if (axi_w_ready)  w_done  <= 1'b1;
                end
                ST_B: if (axi_b_valid) begin
                    rsp_valid <= 1'b1;
                    rsp_last  <= 1'b1;
                    rsp_err   <= (axi_b_resp != RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

endmodule
